// File: rtl/clock_divider_pkg.sv
// rtl/clock_divider_pkg.sv - shared constants and divisor type for the multi-channel clock divider
package clock_divider_pkg;
  localparam int CNT_W_DEFAULT = 20;
  localparam int N_CH_MAX      = 16;

  typedef logic [CNT_W_DEFAULT-1:0] div_t;
endpackage

// File: rtl/clock_divider_ch.sv
// rtl/clock_divider_ch.sv - one divider channel: half-period counter, shadow divisor, clk_out and tick flops
module clock_divider_ch
  import clock_divider_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             sync_i,
  output logic             clk_out_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_lat_q, div_lat_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  // div_i is only sampled while idle, on sync, or at terminal count, so a half-period never short-cycles.
  always_comb begin
    cnt_d     = cnt_q;
    div_lat_d = div_lat_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    if (!en_i || sync_i) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      div_lat_d = div_i;
    end else if (cnt_q == div_lat_q) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
      tick_d    = 1'b1;
      div_lat_d = div_i;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_lat_q <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_lat_q <= div_lat_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clock_divider_mc.sv
// rtl/clock_divider_mc.sv - N_CH independent programmable dividers; CLKDIV_SYNC_EN adds the sync realign input
module clock_divider_mc
  import clock_divider_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH*CNT_W-1:0] div,
`ifdef CLKDIV_SYNC_EN
  input  logic                  sync,
`endif
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       tick
);

  logic sync_int;

`ifdef CLKDIV_SYNC_EN
  assign sync_int = sync;
`else
  assign sync_int = 1'b0;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clock_divider_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (en[i]),
      .div_i    (div[i*CNT_W +: CNT_W]),
      .sync_i   (sync_int),
      .clk_out_o(clk_out[i]),
      .tick_o   (tick[i])
    );
  end

endmodule
